// File: rtl/ppi_pkg.sv
// Shared encodings for the 8255A-style port control stage: mode and direction
// values plus the default port width.
package ppi_pkg;

    localparam int PPI_WIDTH = 8;

    typedef enum logic {
        MODE0 = 1'b0,
        MODE1 = 1'b1
    } ppi_mode_e;

    typedef enum logic {
        DIR_OUT = 1'b0,
        DIR_IN  = 1'b1
    } ppi_dir_e;

endpackage

// File: rtl/ppi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pad signal, with single-cycle
// rise/fall pulses derived from the synchronised level and a delayed copy.
module ppi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_reg;
    logic                   prev_reg;

    // Preset to the idle level so a reset never manufactures an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_reg <= {SYNC_STAGES{RESET_VAL}};
            prev_reg  <= RESET_VAL;
        end else begin
            chain_reg <= {chain_reg[SYNC_STAGES-2:0], async_in};
            prev_reg  <= chain_reg[SYNC_STAGES-1];
        end
    end

    assign level = chain_reg[SYNC_STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/ppi_port_handshake.sv
// One PPI port: output latch, input latch and Mode 0/Mode 1 strobed handshake
// (STB/IBF/INTR for input, OBF/ACK/INTR for output) feeding the pad buffer.
module ppi_port_handshake
    import ppi_pkg::*;
#(
    parameter int WIDTH       = PPI_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic             cfg_mode,
    input  logic             cfg_dir,
    input  logic             inte_we,
    input  logic             inte_d,
    input  logic             wr_pulse,
    input  logic             rd_pulse,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    input  logic             stb_n,
    input  logic             ack_n,
    output logic             ibf,
    output logic             obf_n,
    output logic             intr,
    output logic             ovr
);

    ppi_mode_e        mode_reg, mode_next;
    ppi_dir_e         dir_reg, dir_next;
    logic             inte_reg, inte_next;
    logic [WIDTH-1:0] pin_out_reg, pin_out_next;
    logic [WIDTH-1:0] rdata_reg, rdata_next;
    logic [WIDTH-1:0] in_latch_reg, in_latch_next;
    logic             ibf_reg, ibf_next;
    logic             obf_n_reg, obf_n_next;
    logic             intr_reg, intr_next;
    logic             ovr_reg, ovr_next;

    logic             stb_level, stb_rise, stb_fall;
    logic             ack_level, ack_rise, ack_fall;
    logic [WIDTH-1:0] pin_sync_reg [SYNC_STAGES];
    logic [WIDTH-1:0] pin_sync;

    ppi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_stb_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (stb_n),
        .level    (stb_level),
        .rise     (stb_rise),
        .fall     (stb_fall)
    );

    ppi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_ack_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (ack_n),
        .level    (ack_level),
        .rise     (ack_rise),
        .fall     (ack_fall)
    );

    // Pad data only needs a level synchroniser; it is sampled on stb/rd events.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_pin_sync
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pin_sync_reg[gi] <= '0;
                end else if (gi == 0) begin
                    pin_sync_reg[gi] <= pin_in;
                end else begin
                    pin_sync_reg[gi] <= pin_sync_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign pin_sync = pin_sync_reg[SYNC_STAGES-1];

    always_comb begin
        mode_next     = mode_reg;
        dir_next      = dir_reg;
        inte_next     = inte_reg;
        pin_out_next  = pin_out_reg;
        rdata_next    = rdata_reg;
        in_latch_next = in_latch_reg;
        ibf_next      = ibf_reg;
        obf_n_next    = obf_n_reg;
        intr_next     = intr_reg;
        ovr_next      = ovr_reg;

        if (cfg_we) begin
            // A configuration write pre-empts every other event this cycle.
            mode_next    = ppi_mode_e'(cfg_mode);
            dir_next     = ppi_dir_e'(cfg_dir);
            pin_out_next = '0;
            ibf_next     = 1'b0;
            ovr_next     = 1'b0;
            intr_next    = 1'b0;
            obf_n_next   = 1'b1;
        end else begin
            if (inte_we) begin
                inte_next = inte_d;
            end
            if (wr_pulse) begin
                pin_out_next = cpu_wdata;
            end
            if (rd_pulse) begin
                if (dir_reg == DIR_IN) begin
                    rdata_next = (mode_reg == MODE1) ? in_latch_reg : pin_sync;
                end else begin
                    rdata_next = pin_out_reg;
                end
            end

            if (mode_reg == MODE0) begin
                ibf_next   = 1'b0;
                obf_n_next = 1'b1;
                intr_next  = 1'b0;
            end else if (dir_reg == DIR_IN) begin
                obf_n_next = 1'b1;
                if (rd_pulse) begin
                    ibf_next  = 1'b0;
                    intr_next = 1'b0;
                    ovr_next  = 1'b0;
                end
                // Strobe fall is applied after the read so a new byte is never lost.
                if (stb_fall) begin
                    in_latch_next = pin_sync;
                    ibf_next      = 1'b1;
                    if (ibf_reg) begin
                        ovr_next = 1'b1;
                    end
                end
                if (stb_rise && inte_reg && ibf_reg && !rd_pulse) begin
                    intr_next = 1'b1;
                end
            end else begin
                ibf_next = 1'b0;
                if (ack_fall) begin
                    obf_n_next = 1'b1;
                end
                if (ack_rise && inte_reg && obf_n_reg) begin
                    intr_next = 1'b1;
                end
                // A CPU write outranks a coincident acknowledge.
                if (wr_pulse) begin
                    obf_n_next = 1'b0;
                    intr_next  = 1'b0;
                end
            end

            if (!inte_reg) begin
                intr_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg     <= MODE0;
            dir_reg      <= DIR_IN;
            inte_reg     <= 1'b0;
            pin_out_reg  <= '0;
            rdata_reg    <= '0;
            in_latch_reg <= '0;
            ibf_reg      <= 1'b0;
            obf_n_reg    <= 1'b1;
            intr_reg     <= 1'b0;
            ovr_reg      <= 1'b0;
        end else begin
            mode_reg     <= mode_next;
            dir_reg      <= dir_next;
            inte_reg     <= inte_next;
            pin_out_reg  <= pin_out_next;
            rdata_reg    <= rdata_next;
            in_latch_reg <= in_latch_next;
            ibf_reg      <= ibf_next;
            obf_n_reg    <= obf_n_next;
            intr_reg     <= intr_next;
            ovr_reg      <= ovr_next;
        end
    end

    assign pin_out   = pin_out_reg;
    assign pin_oe    = {WIDTH{dir_reg == DIR_OUT}};
    assign cpu_rdata = rdata_reg;
    assign ibf       = ibf_reg;
    assign obf_n     = obf_n_reg;
    assign intr      = intr_reg;
    assign ovr       = ovr_reg;

endmodule

// File: tb/tb_ppi_port_handshake.sv
module tb_ppi_port_handshake;

    localparam int W = 8;

    localparam int S_PIN_OUT = 0;
    localparam int S_PIN_OE  = 1;
    localparam int S_RDATA   = 2;
    localparam int S_IBF     = 3;
    localparam int S_OBF_N   = 4;
    localparam int S_INTR    = 5;
    localparam int S_OVR     = 6;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] val;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         cfg_we, cfg_mode, cfg_dir;
    logic         inte_we, inte_d;
    logic         wr_pulse, rd_pulse;
    logic [W-1:0] cpu_wdata, cpu_rdata;
    logic [W-1:0] pin_in, pin_out, pin_oe;
    logic         stb_n, ack_n;
    logic         ibf, obf_n, intr, ovr;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ppi_port_handshake #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_mode  (cfg_mode),
        .cfg_dir   (cfg_dir),
        .inte_we   (inte_we),
        .inte_d    (inte_d),
        .wr_pulse  (wr_pulse),
        .rd_pulse  (rd_pulse),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .pin_in    (pin_in),
        .pin_out   (pin_out),
        .pin_oe    (pin_oe),
        .stb_n     (stb_n),
        .ack_n     (ack_n),
        .ibf       (ibf),
        .obf_n     (obf_n),
        .intr      (intr),
        .ovr       (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            S_PIN_OUT: return pin_out;
            S_PIN_OE:  return pin_oe;
            S_RDATA:   return cpu_rdata;
            S_IBF:     return {7'd0, ibf};
            S_OBF_N:   return {7'd0, obf_n};
            S_INTR:    return {7'd0, intr};
            S_OVR:     return {7'd0, ovr};
            default:   return 8'hxx;
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input logic [7:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_cfg(input logic m, input logic d);
        cfg_mode = m;
        cfg_dir  = d;
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic do_wr(input logic [7:0] d);
        cpu_wdata = d;
        wr_pulse  = 1'b1;
        tick();
        wr_pulse  = 1'b0;
    endtask

    task automatic do_rd();
        rd_pulse = 1'b1;
        tick();
        rd_pulse = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] d);
        pin_in = d;
        tick(3);
        stb_n = 1'b0;
        tick(4);
        stb_n = 1'b1;
        tick(4);
    endtask

    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = observe(e.sel);
                n_checks++;
                if (act !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %02h expected %02h", e.name, act, e.val);
                end else begin
                    $display("ok   %s: %02h", e.name, act);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        cfg_we = 1'b0; cfg_mode = 1'b0; cfg_dir = 1'b0;
        inte_we = 1'b0; inte_d = 1'b0;
        wr_pulse = 1'b0; rd_pulse = 1'b0;
        cpu_wdata = '0; pin_in = '0;
        stb_n = 1'b1; ack_n = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);

        expect_val("reset_pin_oe", S_PIN_OE, 8'h00);
        expect_val("reset_pin_out", S_PIN_OUT, 8'h00);
        expect_val("reset_rdata", S_RDATA, 8'h00);
        expect_val("reset_ibf", S_IBF, 8'h00);
        expect_val("reset_obf_n", S_OBF_N, 8'h01);
        expect_val("reset_intr", S_INTR, 8'h00);
        expect_val("reset_ovr", S_OVR, 8'h00);
        tick();

        do_cfg(1'b0, 1'b0);
        do_wr(8'hA5);
        expect_val("m0_pin_out", S_PIN_OUT, 8'hA5);
        expect_val("m0_pin_oe", S_PIN_OE, 8'hFF);
        do_rd();
        expect_val("m0_rd_out", S_RDATA, 8'hA5);
        expect_val("m0_obf_n", S_OBF_N, 8'h01);
        do_cfg(1'b0, 1'b1);
        expect_val("m0_in_pin_oe", S_PIN_OE, 8'h00);
        expect_val("m0_cfg_clr_out", S_PIN_OUT, 8'h00);
        pin_in = 8'h77;
        tick(3);
        do_rd();
        expect_val("m0_rd_in", S_RDATA, 8'h77);

        do_cfg(1'b1, 1'b1);
        inte_d = 1'b1; inte_we = 1'b1; tick(); inte_we = 1'b0;
        pin_in = 8'h3C;
        tick(3);
        stb_n = 1'b0;
        tick(2);
        expect_val("m1_ibf_edge2", S_IBF, 8'h00);
        tick();
        expect_val("m1_ibf_edge3", S_IBF, 8'h01);
        tick();
        stb_n = 1'b1;
        tick(2);
        expect_val("m1_intr_early", S_INTR, 8'h00);
        tick();
        expect_val("m1_intr_set", S_INTR, 8'h01);
        do_rd();
        expect_val("m1_rd_data", S_RDATA, 8'h3C);
        expect_val("m1_rd_ibf", S_IBF, 8'h00);
        expect_val("m1_rd_intr", S_INTR, 8'h00);

        strobe(8'h3C);
        expect_val("ovr_first_intr", S_INTR, 8'h01);
        expect_val("ovr_first_ovr", S_OVR, 8'h00);
        strobe(8'hC3);
        expect_val("ovr_set", S_OVR, 8'h01);
        expect_val("ovr_ibf", S_IBF, 8'h01);
        do_rd();
        expect_val("ovr_rd_data", S_RDATA, 8'hC3);
        expect_val("ovr_rd_clr", S_OVR, 8'h00);

        do_cfg(1'b1, 1'b0);
        expect_val("m1o_cfg_obf_n", S_OBF_N, 8'h01);
        expect_val("m1o_cfg_intr", S_INTR, 8'h00);
        do_wr(8'h5A);
        expect_val("m1o_wr_obf_n", S_OBF_N, 8'h00);
        expect_val("m1o_wr_pin_out", S_PIN_OUT, 8'h5A);
        ack_n = 1'b0;
        tick(2);
        expect_val("m1o_ack_early", S_OBF_N, 8'h00);
        tick();
        expect_val("m1o_ack_obf_n", S_OBF_N, 8'h01);
        ack_n = 1'b1;
        tick(3);
        expect_val("m1o_ack_intr", S_INTR, 8'h01);
        do_wr(8'h11);
        expect_val("m1o_wr2_intr", S_INTR, 8'h00);
        expect_val("m1o_wr2_obf_n", S_OBF_N, 8'h00);

        ack_n = 1'b0; tick(4); ack_n = 1'b1; tick(4);
        expect_val("inte_pre_intr", S_INTR, 8'h01);
        inte_d = 1'b0; inte_we = 1'b1; tick(); inte_we = 1'b0;
        tick();
        expect_val("inte_off_intr", S_INTR, 8'h00);

        do_wr(8'h22);
        ack_n = 1'b0; tick(4); ack_n = 1'b1; tick(4);
        expect_val("coll_pre_obf_n", S_OBF_N, 8'h01);
        ack_n = 1'b0;
        tick(2);
        cpu_wdata = 8'h99;
        wr_pulse  = 1'b1;
        tick();
        wr_pulse  = 1'b0;
        expect_val("coll_obf_n", S_OBF_N, 8'h00);
        expect_val("coll_pin_out", S_PIN_OUT, 8'h99);
        tick();
        expect_val("coll_obf_n_hold", S_OBF_N, 8'h00);
        ack_n = 1'b1;
        tick(4);

        do_cfg(1'b1, 1'b1);
        pin_in = 8'h44;
        tick(3);
        stb_n = 1'b0;
        tick(4);
        expect_val("rst_pre_ibf", S_IBF, 8'h01);
        tick();
        rst = 1'b1;
        #2;
        expect_val("rst_ibf", S_IBF, 8'h00);
        expect_val("rst_obf_n", S_OBF_N, 8'h01);
        expect_val("rst_pin_oe", S_PIN_OE, 8'h00);
        tick();
        rst = 1'b0;
        tick(4);
        stb_n = 1'b1;
        tick(4);
        expect_val("rst_post_ibf", S_IBF, 8'h00);
        expect_val("rst_post_intr", S_INTR, 8'h00);

        tick(2);
        @(negedge clk);
        #1;

        n_checks++;
        if (ibf !== 1'b0) begin
            n_fail++;
            $display("FAIL final_ibf: got %b expected 0", ibf);
        end else begin
            $display("ok   final_ibf: %b", ibf);
        end

        n_checks++;
        if (obf_n !== 1'b1) begin
            n_fail++;
            $display("FAIL final_obf_n: got %b expected 1", obf_n);
        end else begin
            $display("ok   final_obf_n: %b", obf_n);
        end

        n_checks++;
        if (intr !== 1'b0) begin
            n_fail++;
            $display("FAIL final_intr: got %b expected 0", intr);
        end else begin
            $display("ok   final_intr: %b", intr);
        end

        n_checks++;
        if (ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL final_ovr: got %b expected 0", ovr);
        end else begin
            $display("ok   final_ovr: %b", ovr);
        end

        n_checks++;
        if (pin_oe !== 8'h00) begin
            n_fail++;
            $display("FAIL final_pin_oe: got %02h expected 00", pin_oe);
        end else begin
            $display("ok   final_pin_oe: %02h", pin_oe);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
